// File: rtl/mouse_pkg.sv
// -----------------------------------------------------------------------------
// mouse_pkg
// Shared definitions for the PS/2 mouse packet tracker:
//   - mouse_state_e : packet assembly FSM states
//   - STAT_BIT_*    : bit positions inside PS/2 packet byte 0 (status byte)
// -----------------------------------------------------------------------------
package mouse_pkg;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    UPDATE  = 2'd3
  } mouse_state_e;

  localparam int STAT_BIT_SYNC = 3;  // always 1 in a genuine status byte
  localparam int STAT_BIT_XS   = 4;  // dX sign
  localparam int STAT_BIT_YS   = 5;  // dY sign
  localparam int STAT_BIT_XO   = 6;  // dX overflow
  localparam int STAT_BIT_YO   = 7;  // dY overflow

endpackage

// File: rtl/mouse_axis_update.sv
// -----------------------------------------------------------------------------
// mouse_axis_update
// One axis of the pointer integrator: builds the 9-bit signed delta from the
// packet bytes (saturating on the overflow flag), adds it to the current
// position (optionally negated) and clamps the result to 0..LIMIT-1.
// Ports:
//   pos_i   current absolute position
//   mag_i   low 8 bits of the delta (packet byte 1 or 2)
//   sign_i  delta sign bit from the status byte
//   ovf_i   overflow flag from the status byte
//   delta_o saturated 9-bit two's-complement delta (not negated)
//   pos_o   new clamped position
// -----------------------------------------------------------------------------
module mouse_axis_update #(
  parameter int LIMIT   = 160,
  parameter int COORD_W = 8,
  parameter bit NEGATE  = 1'b0
) (
  input  logic [COORD_W-1:0] pos_i,
  input  logic [7:0]         mag_i,
  input  logic               sign_i,
  input  logic               ovf_i,
  output logic [8:0]         delta_o,
  output logic [COORD_W-1:0] pos_o
);

  // Two guard bits: position is unsigned, delta spans -256..+256 after
  // negation, so the sum never wraps.
  localparam int SW = COORD_W + 2;
  localparam logic signed [SW-1:0] HI = SW'(LIMIT - 1);

  logic signed [SW-1:0] delta_ext;
  logic signed [SW-1:0] step;
  logic signed [SW-1:0] sum;

  always_comb begin
    if (ovf_i) begin
      delta_o = sign_i ? 9'h100 : 9'h0FF;
    end else begin
      delta_o = {sign_i, mag_i};
    end
    delta_ext = {{(SW-9){delta_o[8]}}, delta_o};
    step      = NEGATE ? -delta_ext : delta_ext;
    sum       = $signed({2'b00, pos_i}) + step;
    if (sum < 0) begin
      pos_o = '0;
    end else if (sum > HI) begin
      pos_o = HI[COORD_W-1:0];
    end else begin
      pos_o = sum[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/mouse_packet_tracker.sv
// -----------------------------------------------------------------------------
// mouse_packet_tracker
// Assembles 3-byte PS/2 movement packets from the receiver byte stream,
// resynchronises on framing loss and integrates dX/dY into clamped absolute
// coordinates for the bus-side mouse registers.
// Ports:
//   CLK, RESET             clock, synchronous active-high reset
//   ENABLE                 0 holds the FSM idle and discards bytes
//   BYTE_IN/BYTE_READY     received byte and its 1-cycle strobe
//   BYTE_ERROR_CODE        nonzero marks a receiver error on this byte
//   MOUSE_STATUS/DX/DY     status byte and saturated deltas of last packet
//   MOUSE_X/MOUSE_Y        clamped absolute position (Y=0 is screen top)
//   PACKET_VALID           1-cycle pulse when the registers above update
//   RESYNC_CNT             saturating count of discarded bytes/packets
//   DBG_STATE              current FSM state
// Handshake: a byte is consumed in exactly the cycle BYTE_READY is high; there
// is no back-pressure, so one byte per cycle is always accepted, including
// during UPDATE where the byte is treated as a new status-byte candidate.
// -----------------------------------------------------------------------------
module mouse_packet_tracker
  import mouse_pkg::*;
#(
  parameter int X_MAX   = 160,
  parameter int Y_MAX   = 120,
  parameter int COORD_W = 8,
  parameter int GAP_CYC = 200000
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic [7:0]         BYTE_IN,
  input  logic               BYTE_READY,
  input  logic [1:0]         BYTE_ERROR_CODE,
  output logic [7:0]         MOUSE_STATUS,
  output logic [8:0]         MOUSE_DX,
  output logic [8:0]         MOUSE_DY,
  output logic [COORD_W-1:0] MOUSE_X,
  output logic [COORD_W-1:0] MOUSE_Y,
  output logic               PACKET_VALID,
  output logic [7:0]         RESYNC_CNT,
  output mouse_state_e       DBG_STATE
);

  localparam int GW = $clog2(GAP_CYC + 1);

  mouse_state_e      state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [7:0]        stat_q, stat_d;   // status byte of packet in progress
  logic [7:0]        b1_q, b1_d;
  logic [7:0]        b2_q, b2_d;
  logic [7:0]        rcnt_q, rcnt_d;
  logic [7:0]        ostat_q, ostat_d;
  logic [8:0]        dx_q, dx_d;
  logic [8:0]        dy_q, dy_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic              pv_q, pv_d;

  logic              rcnt_inc;
  logic              do_update;
  logic              byte_err;
  logic [8:0]        dx_new, dy_new;
  logic [COORD_W-1:0] x_new, y_new;

  assign byte_err = (BYTE_ERROR_CODE != 2'b00);

  mouse_axis_update #(.LIMIT(X_MAX), .COORD_W(COORD_W), .NEGATE(1'b0)) u_axis_x (
    .pos_i   (x_q),
    .mag_i   (b1_q),
    .sign_i  (stat_q[STAT_BIT_XS]),
    .ovf_i   (stat_q[STAT_BIT_XO]),
    .delta_o (dx_new),
    .pos_o   (x_new)
  );

  // Screen Y grows downward while PS/2 dY is positive upward.
  mouse_axis_update #(.LIMIT(Y_MAX), .COORD_W(COORD_W), .NEGATE(1'b1)) u_axis_y (
    .pos_i   (y_q),
    .mag_i   (b2_q),
    .sign_i  (stat_q[STAT_BIT_YS]),
    .ovf_i   (stat_q[STAT_BIT_YO]),
    .delta_o (dy_new),
    .pos_o   (y_new)
  );

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    stat_d    = stat_q;
    b1_d      = b1_q;
    b2_d      = b2_q;
    rcnt_inc  = 1'b0;
    do_update = 1'b0;

    if (!ENABLE) begin
      // Partial packet silently dropped; not counted as a resync.
      state_d = WAIT_B0;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        WAIT_B0, UPDATE: begin
          do_update = (state_q == UPDATE);
          state_d   = WAIT_B0;
          gap_d     = '0;
          if (BYTE_READY) begin
            if (!byte_err && BYTE_IN[STAT_BIT_SYNC]) begin
              stat_d  = BYTE_IN;
              state_d = WAIT_B1;
            end else begin
              rcnt_inc = 1'b1;
            end
          end
        end
        WAIT_B1, WAIT_B2: begin
          if (BYTE_READY) begin
            gap_d = '0;
            if (byte_err) begin
              rcnt_inc = 1'b1;
              state_d  = WAIT_B0;
            end else if (state_q == WAIT_B1) begin
              b1_d    = BYTE_IN;
              state_d = WAIT_B2;
            end else begin
              b2_d    = BYTE_IN;
              state_d = UPDATE;
            end
          end else if (gap_q == GW'(GAP_CYC - 1)) begin
            // This idle cycle is the GAP_CYC-th since the last byte.
            rcnt_inc = 1'b1;
            state_d  = WAIT_B0;
            gap_d    = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: state_d = WAIT_B0;
      endcase
    end

    rcnt_d = (rcnt_inc && (rcnt_q != 8'hFF)) ? rcnt_q + 8'd1 : rcnt_q;

    pv_d    = do_update;
    ostat_d = ostat_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    x_d     = x_q;
    y_d     = y_q;
    if (do_update) begin
      ostat_d = stat_q;
      dx_d    = dx_new;
      dy_d    = dy_new;
      x_d     = x_new;
      y_d     = y_new;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= WAIT_B0;
      gap_q   <= '0;
      stat_q  <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      rcnt_q  <= '0;
      ostat_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      x_q     <= COORD_W'(X_MAX / 2);
      y_q     <= COORD_W'(Y_MAX / 2);
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      stat_q  <= stat_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      rcnt_q  <= rcnt_d;
      ostat_q <= ostat_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pv_q    <= pv_d;
    end
  end

  assign MOUSE_STATUS = ostat_q;
  assign MOUSE_DX     = dx_q;
  assign MOUSE_DY     = dy_q;
  assign MOUSE_X      = x_q;
  assign MOUSE_Y      = y_q;
  assign PACKET_VALID = pv_q;
  assign RESYNC_CNT   = rcnt_q;
  assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// -----------------------------------------------------------------------------
// tb_mouse_packet_tracker
// Directed scenarios followed by randomized byte traffic. A packet-level
// reference (byte queue, idle counter, integer arithmetic) predicts every
// output each cycle; literal expectations pin the directed scenarios.
// -----------------------------------------------------------------------------
module tb_mouse_packet_tracker;
  import mouse_pkg::*;

  localparam int X_MAX   = 160;
  localparam int Y_MAX   = 120;
  localparam int COORD_W = 8;
  localparam int GAP_CYC = 40;

  logic               CLK;
  logic               RESET;
  logic               ENABLE;
  logic [7:0]         BYTE_IN;
  logic               BYTE_READY;
  logic [1:0]         BYTE_ERROR_CODE;
  logic [7:0]         MOUSE_STATUS;
  logic [8:0]         MOUSE_DX;
  logic [8:0]         MOUSE_DY;
  logic [COORD_W-1:0] MOUSE_X;
  logic [COORD_W-1:0] MOUSE_Y;
  logic               PACKET_VALID;
  logic [7:0]         RESYNC_CNT;
  mouse_state_e       DBG_STATE;

  int checks = 0;
  int errors = 0;

  mouse_packet_tracker #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .COORD_W(COORD_W), .GAP_CYC(GAP_CYC)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .ENABLE          (ENABLE),
    .BYTE_IN         (BYTE_IN),
    .BYTE_READY      (BYTE_READY),
    .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
    .MOUSE_STATUS    (MOUSE_STATUS),
    .MOUSE_DX        (MOUSE_DX),
    .MOUSE_DY        (MOUSE_DY),
    .MOUSE_X         (MOUSE_X),
    .MOUSE_Y         (MOUSE_Y),
    .PACKET_VALID    (PACKET_VALID),
    .RESYNC_CNT      (RESYNC_CNT),
    .DBG_STATE       (DBG_STATE)
  );

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- reference model ----------------
  int         e_x, e_y, e_dx, e_dy, e_stat, e_rs;
  bit         e_pv;
  logic [7:0] exp_q[$];       // accepted bytes of the packet being assembled
  logic [7:0] done_b0, done_b1, done_b2;
  int         idle_cnt;
  bit         upd_pending;
  bit         armed = 1'b0;

  function automatic int delta(logic ovf, logic sgn, logic [7:0] mag);
    if (ovf) return sgn ? -256 : 255;
    return sgn ? int'(mag) - 256 : int'(mag);
  endfunction

  function automatic int clamp(int v, int lim);
    if (v < 0) return 0;
    if (v > lim - 1) return lim - 1;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp_v);
    end
  endtask

  task automatic bump();
    if (e_rs < 255) e_rs++;
  endtask

  task automatic model_reset();
    e_x = X_MAX / 2; e_y = Y_MAX / 2;
    e_dx = 0; e_dy = 0; e_stat = 0; e_rs = 0; e_pv = 1'b0;
    exp_q.delete(); idle_cnt = 0; upd_pending = 1'b0;
  endtask

  // Consumes the inputs of one cycle; leaves the outputs expected next cycle.
  task automatic model_step();
    e_pv = 1'b0;
    if (upd_pending) begin
      upd_pending = 1'b0;
      if (ENABLE) begin
        e_stat = int'(done_b0);
        e_dx   = delta(done_b0[6], done_b0[4], done_b1);
        e_dy   = delta(done_b0[7], done_b0[5], done_b2);
        e_x    = clamp(e_x + e_dx, X_MAX);
        e_y    = clamp(e_y - e_dy, Y_MAX);
        e_pv   = 1'b1;
      end
    end
    if (!ENABLE) begin
      exp_q.delete();
      idle_cnt = 0;
    end else if (BYTE_READY) begin
      idle_cnt = 0;
      if (exp_q.size() == 0) begin
        if (BYTE_ERROR_CODE == 2'b00 && BYTE_IN[3]) exp_q.push_back(BYTE_IN);
        else bump();
      end else if (BYTE_ERROR_CODE != 2'b00) begin
        exp_q.delete();
        bump();
      end else begin
        exp_q.push_back(BYTE_IN);
        if (exp_q.size() == 3) begin
          done_b0 = exp_q[0]; done_b1 = exp_q[1]; done_b2 = exp_q[2];
          exp_q.delete();
          upd_pending = 1'b1;
        end
      end
    end else if (exp_q.size() != 0) begin
      idle_cnt++;
      if (idle_cnt == GAP_CYC) begin
        exp_q.delete();
        idle_cnt = 0;
        bump();
      end
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  initial begin
    forever begin
      @(negedge CLK);
      if (armed) begin
        chk("packet_valid", int'(PACKET_VALID), int'(e_pv));
        chk("mouse_x", int'(MOUSE_X), e_x);
        chk("mouse_y", int'(MOUSE_Y), e_y);
        chk("mouse_dx", int'($signed(MOUSE_DX)), e_dx);
        chk("mouse_dy", int'($signed(MOUSE_DY)), e_dy);
        chk("mouse_status", int'(MOUSE_STATUS), e_stat);
        chk("resync_cnt", int'(RESYNC_CNT), e_rs);
      end
      if (RESET) begin
        model_reset();
        armed = 1'b1;
      end else if (armed) begin
        model_step();
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [1:0] e);
    BYTE_IN = b; BYTE_ERROR_CODE = e; BYTE_READY = 1'b1;
    cyc(1);
    BYTE_READY = 1'b0; BYTE_ERROR_CODE = 2'b00;
  endtask

  // Sends a packet back to back and checks the n+2 latency plus the outcome.
  task automatic pkt_expect(input string name, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2,
                            input int x, input int y, input int dx, input int dy);
    send_byte(b0, 2'b00);
    send_byte(b1, 2'b00);
    send_byte(b2, 2'b00);
    chk({name, "_pv_n1"}, int'(PACKET_VALID), 0);
    cyc(1);
    chk({name, "_pv_n2"}, int'(PACKET_VALID), 1);
    chk({name, "_x"}, int'(MOUSE_X), x);
    chk({name, "_y"}, int'(MOUSE_Y), y);
    chk({name, "_dx"}, int'($signed(MOUSE_DX)), dx);
    chk({name, "_dy"}, int'($signed(MOUSE_DY)), dy);
    chk({name, "_model_x"}, e_x, x);
    chk({name, "_model_y"}, e_y, y);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET = 1'b1; ENABLE = 1'b1; BYTE_IN = 8'h00; BYTE_READY = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
    cyc(3);
    RESET = 1'b0;
    chk("reset_x", int'(MOUSE_X), 80);
    chk("reset_y", int'(MOUSE_Y), 60);
    chk("reset_pv", int'(PACKET_VALID), 0);
    chk("reset_rs", int'(RESYNC_CNT), 0);
    chk("reset_state", int'(DBG_STATE), int'(WAIT_B0));

    // basic packet
    pkt_expect("t1", 8'h08, 8'h05, 8'h03, 85, 57, 5, 3);
    chk("t1_status", int'(MOUSE_STATUS), 8'h08);
    cyc(1);
    chk("t1_pv_pulse", int'(PACKET_VALID), 0);

    // negative dX and clamps
    pkt_expect("t2a", 8'h18, 8'hAE, 8'h00, 3, 57, -82, 0);
    pkt_expect("t2b", 8'h18, 8'hF6, 8'h00, 0, 57, -10, 0);
    pkt_expect("t2c", 8'h28, 8'h00, 8'hCB, 0, 110, 0, -53);
    pkt_expect("t2d", 8'h28, 8'h00, 8'h80, 0, 119, 0, -128);

    // X overflow saturation
    pkt_expect("t3", 8'h48, 8'h00, 8'h00, 159, 119, 255, 0);

    // misaligned byte then a good packet
    send_byte(8'h05, 2'b00);
    cyc(1);
    chk("t4_rs", int'(RESYNC_CNT), 1);
    pkt_expect("t4", 8'h08, 8'h01, 8'h01, 159, 118, 1, 1);

    // inter-byte gap timeout, exactly GAP_CYC idle cycles
    pkt_expect("t5a", 8'h18, 8'hC5, 8'h00, 100, 118, -59, 0);
    send_byte(8'h08, 2'b00);
    send_byte(8'h02, 2'b00);
    cyc(GAP_CYC);
    chk("t5_rs", int'(RESYNC_CNT), 2);
    pkt_expect("t5b", 8'h08, 8'h01, 8'h01, 101, 117, 1, 1);

    // GAP_CYC-1 idle cycles keep the packet alive
    send_byte(8'h08, 2'b00);
    send_byte(8'h02, 2'b00);
    cyc(GAP_CYC - 1);
    send_byte(8'h03, 2'b00);
    cyc(1);
    chk("gap_edge_pv", int'(PACKET_VALID), 1);
    chk("gap_edge_x", int'(MOUSE_X), 103);
    chk("gap_edge_y", int'(MOUSE_Y), 114);
    chk("gap_edge_rs", int'(RESYNC_CNT), 2);

    // errored byte 2
    send_byte(8'h08, 2'b00);
    send_byte(8'h01, 2'b00);
    send_byte(8'h07, 2'b01);
    cyc(1);
    chk("t6_pv", int'(PACKET_VALID), 0);
    chk("t6_x", int'(MOUSE_X), 103);
    chk("t6_y", int'(MOUSE_Y), 114);
    chk("t6_rs", int'(RESYNC_CNT), 3);

    // ENABLE drop mid packet
    send_byte(8'h08, 2'b00);
    send_byte(8'h05, 2'b00);
    ENABLE = 1'b0;
    cyc(2);
    ENABLE = 1'b1;
    chk("t6_en_rs", int'(RESYNC_CNT), 3);
    chk("t6_en_state", int'(DBG_STATE), int'(WAIT_B0));
    pkt_expect("t6b", 8'h08, 8'h04, 8'h00, 107, 114, 4, 0);

    // reset mid packet
    send_byte(8'h08, 2'b00);
    send_byte(8'h05, 2'b00);
    RESET = 1'b1;
    cyc(1);
    RESET = 1'b0;
    chk("mid_rst_x", int'(MOUSE_X), 80);
    chk("mid_rst_y", int'(MOUSE_Y), 60);
    chk("mid_rst_rs", int'(RESYNC_CNT), 0);
    chk("mid_rst_status", int'(MOUSE_STATUS), 0);
    chk("mid_rst_state", int'(DBG_STATE), int'(WAIT_B0));

    // resync counter saturation
    for (int i = 0; i < 260; i++) send_byte(8'h00, 2'b00);
    cyc(1);
    chk("rs_sat", int'(RESYNC_CNT), 255);
    RESET = 1'b1;
    cyc(1);
    RESET = 1'b0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        ENABLE = 1'b0;
        cyc($urandom_range(1, 3));
        ENABLE = 1'b1;
      end else if (r < 5) begin
        RESET = 1'b1;
        cyc(1);
        RESET = 1'b0;
      end else if (r < 9) begin
        cyc($urandom_range(GAP_CYC - 2, GAP_CYC + 2));
      end else begin
        logic [7:0] b;
        logic [1:0] e;
        b = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) b[3] = 1'b1;
        e = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        send_byte(b, e);
        cyc($urandom_range(0, 2));
      end
    end
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
